// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-align a fetch address; the low two bits never reach memory.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush wins over push in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fetch_entry_t  push_entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          wr_en_c;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en_c  = 1'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en_c = push_i;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if (wr_en_c) mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one imem read at a time and buffers
// returned instructions for decode; redirects flush and restart fetch.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned     DEPTH    = 4,
  parameter  logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  input  logic               instr_ready_i
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            req_q, req_d;

  logic            push_c, flush_c, pop_c;
  logic            credit_idle_c, credit_push_c;
  logic [PC_W-1:0] redir_pc_c;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry, head;

  assign pop_c      = instr_valid_o & instr_ready_i;
  assign redir_pc_c = align_pc(redirect_pc_i);
  assign push_entry = '{pc: fetch_pc_q, instr: imem_data_i};

  // Occupancy after this edge must stay below DEPTH to launch another read.
  assign credit_idle_c = (32'(fifo_count) - 32'(pop_c)) < DEPTH;
  assign credit_push_c = (32'(fifo_count) - 32'(pop_c) + 32'd1) < DEPTH;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push_c     = 1'b0;
    flush_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          flush_c    = 1'b1;
          fetch_pc_d = redir_pc_c;
          state_d    = REQ;
        end else if (credit_idle_c) begin
          state_d = REQ;
        end
      end
      REQ, DRAIN: begin
        if (redirect_i) begin
          flush_c = 1'b1;
          // An ack landing with the redirect is dropped and the new PC issues at once.
          if (imem_ack_i) begin
            fetch_pc_d = redir_pc_c;
            state_d    = REQ;
          end else begin
            pend_pc_d = redir_pc_c;
            state_d   = DRAIN;
          end
        end else if (imem_ack_i) begin
          if (state_q == DRAIN) begin
            fetch_pc_d = pend_pc_q;
            state_d    = REQ;
          end else begin
            push_c     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            state_d    = credit_push_c ? REQ : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      req_q      <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push_c),
    .push_entry_i (push_entry),
    .pop_i        (pop_c),
    .flush_i      (flush_c),
    .count_o      (fifo_count),
    .valid_o      (instr_valid_o),
    .head_o       (head)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = head.instr;
  assign instr_pc_o  = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by random traffic,
// all checked against a stream-level model of fetch and delivery.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Model: queue occupancy, next PC decode should see, next PC memory should be
  // asked for, and whether the outstanding read is stale (issued before a redirect).
  int          occ;
  logic [31:0] exp_pc;
  logic [31:0] fetch_next;
  logic        dropping;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    occ        = 0;
    exp_pc     = RESET_PC;
    fetch_next = RESET_PC;
    dropping   = 1'b0;
  endtask

  // Called just after an edge; asserts reset asynchronously and releases it two edges later.
  task automatic do_reset();
    rst_i         = 1'b0;
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #1;
    chk("rst_req",   imem_req_o,    32'd0);
    chk("rst_valid", instr_valid_o, 32'd0);
    chk("rst_addr",  imem_addr_o,   RESET_PC);
    chk("rst_instr", instr_o,       32'd0);
    chk("rst_pc",    instr_pc_o,    32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
    imem_data_i = memf(imem_addr_o);
  endtask

  // Advance one cycle with the inputs currently applied, then check the new outputs.
  task automatic tick();
    logic        req_p, ack_p, red_p, pop_p, drop_p, kept;
    logic [31:0] addr_p, tgt;
    req_p  = imem_req_o;
    ack_p  = imem_ack_i;
    red_p  = redirect_i;
    addr_p = imem_addr_o;
    tgt    = redirect_pc_i & ~32'h3;
    pop_p  = instr_valid_o & instr_ready_i;
    drop_p = dropping;
    if (pop_p) begin
      chk("pop_pc",    instr_pc_o, exp_pc);
      chk("pop_instr", instr_o,    memf(exp_pc));
      exp_pc += 32'd4;
    end
    @(posedge clk_i);
    #1;
    kept = req_p & ack_p & !red_p & !drop_p;
    if (red_p) begin
      occ        = 0;
      exp_pc     = tgt;
      fetch_next = tgt;
      dropping   = req_p & !ack_p;
    end else begin
      occ = occ - int'(pop_p) + int'(kept);
      if (kept) fetch_next += 32'd4;
      if (req_p & ack_p) dropping = 1'b0;
    end
    chk("req",   imem_req_o,
        red_p | (req_p & (!ack_p | drop_p)) | (occ < int'(DEPTH)));
    chk("valid", instr_valid_o, occ != 0);
    if (imem_req_o && !dropping) chk("addr", imem_addr_o, fetch_next);
    if (req_p && !ack_p)         chk("addr_hold", imem_addr_o, addr_p);
    imem_data_i = memf(imem_addr_o);
  endtask

  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_ack_i    = 1'b0;
    imem_data_i   = 32'h0;
    instr_ready_i = 1'b0;
    model_reset();
    #2;

    // Zero-wait memory, decode always ready: one instruction per cycle.
    do_reset();
    imem_ack_i    = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    chk("t1_req_rise", imem_req_o, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_pc_seq", instr_pc_o, 32'(i * 4));
    end

    // Decode stalled: queue fills, fetch stops, one pop restarts it.
    do_reset();
    imem_ack_i    = 1'b1;
    instr_ready_i = 1'b0;
    repeat (5) tick();
    chk("t2_full_noreq", imem_req_o, 32'd0);
    tick();
    chk("t2_still_noreq", imem_req_o, 32'd0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("t2_req_after_pop", imem_req_o,  32'd1);
    chk("t2_addr_after_pop", imem_addr_o, 32'h10);

    // 3-cycle latency with a redirect while the read is in flight.
    do_reset();
    instr_ready_i = 1'b1;
    tick();
    chk("t3_req", imem_req_o, 32'd1);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chk("t3_addr_held", imem_addr_o, 32'h0);
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    chk("t3_new_addr", imem_addr_o, 32'h100);
    repeat (2) tick();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    chk("t3_first_valid", instr_valid_o, 32'd1);
    chk("t3_first_pc",    instr_pc_o,    32'h100);

    // Redirect coinciding with an ack, unaligned target.
    imem_ack_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    tick();
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    chk("t4_addr",  imem_addr_o,   32'h200);
    chk("t4_empty", instr_valid_o, 32'd0);

    // Two redirects while draining, then PC wrap at the top of memory.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_pc_i = 32'h80;
    tick();
    redirect_i = 1'b0;
    chk("t5_drain_hold", imem_addr_o, 32'h200);
    imem_ack_i = 1'b1;
    tick();
    chk("t5_last_wins", imem_addr_o, 32'h80);
    tick();
    chk("t5_pc_80", instr_pc_o, 32'h80);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("t5_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_addr", imem_addr_o, 32'h0);
    instr_ready_i = 1'b0;
    imem_ack_i    = 1'b0;
    tick();
    chk("t5_top_pc", instr_pc_o, 32'hFFFF_FFFC);

    // Asynchronous reset with a read outstanding and the queue non-empty.
    chk("t6_pre_req",   imem_req_o,    32'd1);
    chk("t6_pre_valid", instr_valid_o, 32'd1);
    do_reset();
    tick();
    chk("t6_restart_req",  imem_req_o,  32'd1);
    chk("t6_restart_addr", imem_addr_o, RESET_PC);

    // Random traffic across several memory-latency / decode-stall mixes.
    for (int phase = 0; phase < 4; phase++) begin
      int ack_pct;
      int rdy_pct;
      ack_pct = (phase == 0) ? 100 : (phase == 1) ? 60 : (phase == 2) ? 25 : 80;
      rdy_pct = (phase == 0) ? 90  : (phase == 1) ? 50 : (phase == 2) ? 80 : 20;
      for (int c = 0; c < 500; c++) begin
        imem_ack_i    = imem_req_o && (int'($urandom_range(0, 99)) < ack_pct);
        instr_ready_i = int'($urandom_range(0, 99)) < rdy_pct;
        redirect_i    = $urandom_range(0, 99) < 5;
        redirect_pc_i = ($urandom_range(0, 3) == 0) ?
                        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage placed between a variable-latency instruction memory and the single-cycle CPU's decode path. It owns the fetch PC, issues one word-read at a time over a req/ack handshake, and buffers returned instructions in a small FIFO. Decode pops instructions over a valid/ready interface. A branch/jump redirect flushes the FIFO and restarts fetch at a new PC, discarding any in-flight return.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- redirect_i  in  1  restart fetch at redirect_pc_i; flush the queue
- redirect_pc_i  in  32  new fetch PC; bits [1:0] are ignored and forced to 0
- imem_req_o  out  1  read request
- imem_addr_o  out  32  word-aligned read address
- imem_ack_i  in  1  read complete; imem_data_i is valid in the same cycle
- imem_data_i  in  32  returned instruction
- instr_valid_o  out  1  queue head is valid
- instr_o  out  32  head instruction
- instr_pc_o  out  32  PC of the head instruction
- instr_ready_i  in  1  decode accepts the head this cycle

## Operation
- At most one memory transaction is outstanding at a time.
- A transfer completes on an edge where imem_req_o and imem_ack_i are both 1.
- Once raised, imem_req_o stays high and imem_addr_o stays stable until the ack. A request is never retracted.
- FSM states:
  - IDLE: no request; waiting for credit.
  - REQ: request outstanding; return data is kept.
  - DRAIN: request outstanding; return data is discarded.
- Credit at an edge means: count − pop + push < DEPTH.
  - pop = instr_valid_o & instr_ready_i
  - push = ack of data that is kept
- IDLE → REQ when credit is available. imem_addr_o = fetch_pc.
- REQ on ack, no redirect:
  - Push {data, fetch_pc} into the FIFO.
  - fetch_pc += 4.
  - Stay in REQ (back-to-back) if credit remains; otherwise go to IDLE.
- REQ with redirect_i, no ack in the same cycle:
  - Go to DRAIN.
  - Latch redirect_pc_i into pend_pc.
  - Flush the FIFO.
- REQ with redirect_i and ack in the same cycle:
  - Discard the data.
  - Flush the FIFO.
  - fetch_pc = redirect_pc_i.
  - Go to REQ. This is always possible because the FIFO is empty.
- DRAIN on ack:
  - Discard the data.
  - fetch_pc = pend_pc.
  - Go to REQ.
- DRAIN with a further redirect: update pend_pc (last redirect wins) and flush again.
- IDLE with redirect: fetch_pc = redirect_pc_i, flush, go to REQ.
- Pop and redirect in the same cycle: the pop completes and the queue ends up empty.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 → 0).

## Timing
- Reset values:
  - imem_req_o = 0
  - imem_addr_o = RESET_PC
  - instr_valid_o = 0
  - instr_o = 0
  - instr_pc_o = 0
  - state = IDLE
  - FIFO empty
- After reset release, the first edge moves IDLE → REQ, so imem_req_o rises one cycle after rst_i deasserts.
- Ack in cycle N with an empty FIFO → instr_valid_o = 1 in cycle N+1.
- With a zero-wait memory (ack tied high), steady-state throughput is 1 instruction per cycle.
- Full condition: count = DEPTH.
  - No new request is issued while full.
  - A pop in cycle N allows imem_req_o in cycle N+1.
- Redirect in cycle N: instr_valid_o = 0 in cycle N+1. The first post-redirect instruction appears one cycle after its ack.
- Reset asserted mid-transaction:
  - All outputs return to reset values immediately (asynchronous).
  - The outstanding memory response is the environment's responsibility; this block ignores acks while imem_req_o = 0.
- outputs are registered, except instr_o, instr_pc_o and instr_valid_o, which come directly from the FIFO head registers.

## Structure
- Package fetch_pkg holds:
  - INSTR_W = 32
  - PC_STEP = 4
  - the fetch_state_t enum {IDLE, REQ, DRAIN}
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} entries.
  - Ports: push, pop, flush, count, head outputs.
  - Flush has priority over push in the same cycle.
  - The FSM and fetch_pc live in instr_fetch_queue.

## Test plan
- Reset release, ack tied high, ready tied high → instr_pc_o sequence 0, 4, 8, 12 on consecutive cycles starting 2 cycles after reset release.
- ready held low, DEPTH = 4 → after 4 acks imem_req_o stays 0. One pop → imem_req_o = 1 the next cycle with addr 0x10.
- 3-cycle ack latency, redirect to 0x100 one cycle after req rises → addr held at the old value until the ack, that data dropped, then a req with addr 0x100. First delivered instr_pc_o = 0x100.
- Redirect to 0x203 in the same cycle as the ack → data dropped, next addr 0x200, queue empty next cycle.
- Two redirects (0x40 then 0x80) during DRAIN → only 0x80 is fetched. fetch_pc at 0xFFFF_FFFC wraps to 0x0.
- rst_i pulsed low mid-REQ → imem_req_o and instr_valid_o drop in the same cycle; fetch restarts at RESET_PC.
